// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] ZERO_DATA = '0;
  localparam logic              ERR_NONE  = 1'b0;
  localparam logic              ERR_SET   = 1'b1;
endpackage

// File: rtl/dmem_if.sv
// Load/store request/response bus between the core datapath and the data memory.
interface dmem_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_we;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with registered read data; contents are not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  index,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[index] <= wdata;
    rdata <= mem[index];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, LATENCY wait states, single-cycle response
// with misaligned/out-of-range accesses rejected before they reach the array.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  dmem_if.slave bus
);

  localparam int          IDX_W       = $clog2(DEPTH);
  localparam logic [29:0] DEPTH_WORDS = 30'(DEPTH);
  localparam logic [3:0]  CNT_INIT    = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              we_p0;
  logic [DATA_W-1:0] addr_p0, wdata_p0;
  logic              acc_we;
  logic [DATA_W-1:0] acc_addr, acc_wdata;
  logic              acc_err, resp_nxt, enter_resp;
  logic              err_p1, ld_p1;
  logic [DATA_W-1:0] arr_rdata;

  function automatic logic addr_err(input logic [DATA_W-1:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= DEPTH_WORDS);
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (LATENCY > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end else begin
            state_nxt = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A zero-latency build enters RESP straight from IDLE, so the access must use the live request
  always_comb begin
    acc_we     = (state == IDLE) ? bus.req_we    : we_p0;
    acc_addr   = (state == IDLE) ? bus.req_addr  : addr_p0;
    acc_wdata  = (state == IDLE) ? bus.req_wdata : wdata_p0;
    acc_err    = addr_err(acc_addr);
    resp_nxt   = (state_nxt == RESP);
    enter_resp = resp_nxt && !reset;
  end

  // Stage p0: request capture at acceptance
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req_valid) begin
      we_p0    <= bus.req_we;
      addr_p0  <= bus.req_addr;
      wdata_p0 <= bus.req_wdata;
    end
  end

  // Stage p1: response flags registered into the RESP cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      err_p1 <= ERR_NONE;
      ld_p1  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      err_p1 <= resp_nxt ? acc_err : ERR_NONE;
      ld_p1  <= resp_nxt && !acc_we && !acc_err;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (enter_resp && acc_we && !acc_err),
    .index (acc_addr[IDX_W+1:2]),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_err   = err_p1;
  assign bus.rsp_rdata = ld_p1 ? arr_rdata : ZERO_DATA;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the core datapath's load/store port (address = ALU result, store data = register read port B, load data returned to the result mux).
- Accepts one word request at a time through a valid/ready handshake.
- Models a configurable number of wait states, then returns a single-cycle response.
- Flags misaligned and out-of-range accesses instead of corrupting memory.

Parameters:
- DEPTH, 64: number of 32-bit words stored; must be a power of two, at least 2.
- LATENCY, 2: wait-state cycles between request acceptance and response; range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_ready  output  1  responder can accept a request this cycle.
- rsp_valid  output  1  response present; one-cycle pulse, no backpressure.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  access rejected (misaligned or out of range).

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state IDLE, req_ready=1 (combinational from IDLE), rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter 0.
- Memory contents are not reset.
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid=1 at a rising edge, capture we, addr and wdata.
    - If LATENCY>0: go to WAIT and load counter with LATENCY-1.
    - If LATENCY=0: go to RESP.
  - WAIT: req_ready=0. Decrement counter each edge. When counter=0, go to RESP.
  - RESP: req_ready=0, rsp_valid=1 for exactly this cycle. Always returns to IDLE next edge.
- Latency and throughput:
  - Acceptance at edge N gives rsp_valid high in the cycle after edge N+LATENCY.
  - Maximum throughput is one request per LATENCY+2 cycles.
- Error check, evaluated on the captured address:
  - misaligned = addr[1:0] != 0.
  - out of range = addr[31:2] >= DEPTH (full-width compare; no aliasing).
  - Either condition sets rsp_err=1 and rsp_rdata=0; no write occurs.
- Store: memory is written at the edge entering RESP. In RESP, rsp_rdata=0 and rsp_err=0 (if legal).
- Load: rsp_rdata = mem[addr[log2(DEPTH)+1:2]], registered into the RESP cycle. Reflects all stores completed before it.
- rsp_rdata and rsp_err are held 0 outside RESP.
- Inputs while busy: req_* are ignored while req_ready=0. The request is captured only at acceptance; later input changes have no effect.
- Reset mid-operation (WAIT or RESP entry edge): the transaction is aborted. A pending store is NOT committed; no rsp_valid is produced.
- Reset takes priority over acceptance on the same edge.

Decomposition:
- Shared package dmem_pkg: state enum (IDLE, WAIT, RESP) and the error/zero-data constants.
- One natural sub-module: dmem_array.
  - Single-port synchronous word RAM, DEPTH x 32.
  - Inputs: we, index, wdata. Output: registered rdata.
- The FSM, wait counter and error check stay in dmem_responder.

Test Plan:
- Store then load, LATENCY=2: store addr 0x10 data 0xDEADBEEF accepted at edge 0 → rsp_valid in cycle after edge 2, rsp_err=0, rsp_rdata=0. Load 0x10 → rsp_rdata=0xDEADBEEF.
- Misaligned store: addr 0x13 data 0x12345678 → rsp_err=1, rsp_rdata=0. A subsequent load from 0x10 still returns 0xDEADBEEF.
- Out of range, DEPTH=64: load addr 0x100 (word 64) → rsp_err=1, rsp_rdata=0. Load addr 0xFC → rsp_err=0.
- Handshake: hold req_valid=1 with changing addresses during WAIT → req_ready=0 throughout, only the first address is serviced, and the next acceptance occurs at the edge after RESP.
- Reset during WAIT: store 0x20 data 0xA5A5A5A5, assert reset one cycle after acceptance → no rsp_valid, req_ready=1 after reset. Load 0x20 returns its prior value, not 0xA5A5A5A5.
- LATENCY=0 build: load accepted at edge N → rsp_valid in the cycle immediately after edge N. Back-to-back requests are accepted every 2 cycles.
